// File: rtl/mydiff_stream.sv
// rtl/mydiff_stream.sv - converts a cumulative sample stream into per-frame difference terms
module mydiff_stream #(
    parameter int in_bits   = 16,
    parameter int out_bits  = 16,
    parameter int frame_len = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic [in_bits-1:0]  in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [out_bits-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_first,
    output logic                out_last,
    output logic                sat_flag
);

    localparam int iw = $clog2(frame_len);
    // Wide enough for the unwrapped difference and for the output clamp bounds.
    localparam int dw = (in_bits + 1 > out_bits) ? in_bits + 1 : out_bits;
    localparam logic [iw-1:0] last_idx = iw'(frame_len - 1);
    localparam logic signed [dw-1:0] max_v = {{(dw - out_bits + 1){1'b0}}, {(out_bits - 1){1'b1}}};
    localparam logic signed [dw-1:0] min_v = ~max_v;

    logic [iw-1:0]         idx;
    logic [in_bits-1:0]    prev;
    logic signed [dw-1:0]  cur_ext;
    logic signed [dw-1:0]  base_ext;
    logic signed [dw-1:0]  diff;
    logic [out_bits-1:0]   term;
    logic                  term_sat;
    logic                  accept;

    assign in_ready = !clear && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        cur_ext  = dw'($signed(in_data));
        base_ext = (idx == '0) ? '0 : dw'($signed(prev));
        diff     = cur_ext - base_ext;
        term     = diff[out_bits-1:0];
        term_sat = 1'b0;
        if (diff > max_v) begin
            term     = max_v[out_bits-1:0];
            term_sat = 1'b1;
        end else if (diff < min_v) begin
            term     = min_v[out_bits-1:0];
            term_sat = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            sat_flag  <= 1'b0;
            idx       <= '0;
            prev      <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
            idx       <= '0;
            prev      <= '0;
        end else if (accept) begin
            out_data  <= term;
            out_valid <= 1'b1;
            out_first <= (idx == '0);
            out_last  <= (idx == last_idx);
            prev      <= in_data;
            idx       <= (idx == last_idx) ? '0 : idx + 1'b1;
            if (term_sat) begin
                sat_flag <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mydiff_stream.sv
// tb/tb_mydiff_stream.sv - self-checking bench for mydiff_stream
module tb_mydiff_stream;

    localparam int IB = 8;
    localparam int OB = 8;
    localparam int FL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic [IB-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [OB-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          out_first;
    logic          out_last;
    logic          sat_flag;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int data;
        bit first;
        bit last;
    } term_t;

    term_t exp_q[$];
    int    m_idx;
    int    m_prev;
    bit    m_sat;

    mydiff_stream #(.in_bits(IB), .out_bits(OB), .frame_len(FL)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_first(out_first), .out_last(out_last), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int sout();
        return int'($signed(out_data));
    endfunction

    // Reference: term = sample minus previous sample of the same frame, clamped.
    function automatic term_t model_accept(int x);
        term_t t;
        int d;
        int hi;
        int lo;
        hi = (1 << (OB - 1)) - 1;
        lo = -(1 << (OB - 1));
        d = x - ((m_idx == 0) ? 0 : m_prev);
        if (d > hi) begin d = hi; m_sat = 1'b1; end
        if (d < lo) begin d = lo; m_sat = 1'b1; end
        t.data  = d;
        t.first = (m_idx == 0);
        t.last  = (m_idx == FL - 1);
        m_prev  = x;
        m_idx   = (m_idx + 1) % FL;
        return t;
    endfunction

    task automatic do_clear();
        clear = 1'b1; in_valid = 1'b0;
        cyc();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        cyc(); cyc();
        checks++;
        if ({out_valid, out_first, out_last, sat_flag} !== 4'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs valid=%b first=%b last=%b sat=%b data=%0d expected all 0",
                     out_valid, out_first, out_last, sat_flag, out_data);
        end
        rst_n = 1'b1;
        cyc();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b expected=1", in_ready);
        end
    endtask

    task automatic run_frames(input int vals[], input int exps[], input string name);
        out_ready = 1'b1;
        for (int i = 0; i < vals.size(); i++) begin
            in_data = IB'(vals[i]); in_valid = 1'b1;
            cyc();
            checks++;
            if (out_valid !== 1'b1 || sout() !== exps[i] ||
                out_first !== (i % FL == 0) || out_last !== (i % FL == FL - 1)) begin
                errors++;
                $display("FAIL %s term%0d valid=%b data=%0d first=%b last=%b expected data=%0d first=%b last=%b",
                         name, i, out_valid, sout(), out_first, out_last, exps[i],
                         (i % FL == 0), (i % FL == FL - 1));
            end
        end
        in_valid = 1'b0;
        cyc();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s drain out_valid=%b expected=0", name, out_valid);
        end
    endtask

    task automatic test_single_frame();
        run_frames('{10, 25, 25, 5}, '{10, 15, 0, -20}, "single_frame");
    endtask

    task automatic test_back_to_back();
        run_frames('{3, 7, 7, 7, 4, 4, 9, 9}, '{3, 4, 0, 0, 4, 0, 5, 0}, "two_frames");
    endtask

    task automatic test_saturation();
        do_clear();
        run_frames('{127, -128}, '{127, -128}, "saturation");
        checks++;
        if (sat_flag !== 1'b1) begin
            errors++;
            $display("FAIL sat_set got=%b expected=1", sat_flag);
        end
        cyc(); cyc();
        checks++;
        if (sat_flag !== 1'b1) begin
            errors++;
            $display("FAIL sat_sticky got=%b expected=1", sat_flag);
        end
        do_clear();
        #1;
        checks++;
        if (sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL sat_cleared got=%b expected=0", sat_flag);
        end
    endtask

    task automatic test_backpressure();
        do_clear();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'd5;
        cyc();
        in_data = 8'd9;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || sout() !== 5) begin
                errors++;
                $display("FAIL backpressure_hold%0d in_ready=%b valid=%b data=%0d expected 0/1/5",
                         i, in_ready, out_valid, sout());
            end
            cyc();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release in_ready=%b expected=1", in_ready);
        end
        cyc();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || sout() !== 4 || out_first !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_next valid=%b data=%0d first=%b expected 1/4/0",
                     out_valid, sout(), out_first);
        end
        cyc();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_no_dup valid=%b expected=0", out_valid);
        end
    endtask

    task automatic test_clear();
        do_clear();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'd127; cyc();
        in_data = 8'h80; cyc();
        clear = 1'b1; in_data = 8'd99;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL clear_in_ready got=%b expected=0", in_ready);
        end
        cyc();
        clear = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL clear_flush valid=%b sat=%b expected 0/0", out_valid, sat_flag);
        end
        in_data = 8'd6;
        cyc();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || sout() !== 6 || out_first !== 1'b1 || sat_flag !== 1'b0) begin
            errors++;
            $display("FAIL clear_restart valid=%b data=%0d first=%b sat=%b expected 1/6/1/0",
                     out_valid, sout(), out_first, sat_flag);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'd20;
        cyc();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_first, out_last, sat_flag} !== 4'b0 || out_data !== '0) begin
            errors++;
            $display("FAIL async_reset valid=%b first=%b last=%b sat=%b data=%0d expected all 0",
                     out_valid, out_first, out_last, sat_flag, out_data);
        end
        #2;
        rst_n = 1'b1;
        cyc();
        run_frames('{10, 30}, '{10, 20}, "after_reset");
    endtask

    task automatic test_random();
        int hold;
        term_t t;
        do_clear();
        exp_q.delete();
        m_idx = 0; m_prev = 0; m_sat = 1'b0;
        for (int c = 0; c < 400; c++) begin
            hold      = 0;
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            clear     = ($urandom_range(40) == 0);
            in_data   = IB'($urandom);
            @(negedge clk);
            checks++;
            if (in_ready !== (!clear && (!out_valid || out_ready)) || sat_flag !== m_sat) begin
                errors++;
                $display("FAIL random_ctl cyc%0d in_ready=%b sat=%b expected sat=%b", c, in_ready, sat_flag, m_sat);
            end
            if (out_valid) begin
                checks++;
                if (exp_q.size() != 1) begin
                    errors++;
                    $display("FAIL random_queue cyc%0d pending=%0d expected 1", c, exp_q.size());
                end else if (sout() !== exp_q[0].data || out_first !== exp_q[0].first ||
                             out_last !== exp_q[0].last) begin
                    errors++;
                    $display("FAIL random_term cyc%0d data=%0d first=%b last=%b expected %0d/%b/%b",
                             c, sout(), out_first, out_last, exp_q[0].data, exp_q[0].first, exp_q[0].last);
                end
                if (out_ready) hold = 1;
            end else if (exp_q.size() != 0) begin
                checks++;
                errors++;
                $display("FAIL random_lost cyc%0d out_valid=0 with %0d pending", c, exp_q.size());
                exp_q.delete();
            end
            if (clear) begin
                exp_q.delete();
                m_idx = 0; m_prev = 0; m_sat = 1'b0;
            end else begin
                if (hold == 1 && exp_q.size() > 0) void'(exp_q.pop_front());
                if (in_valid && (!out_valid || out_ready)) begin
                    t = model_accept(int'($signed(in_data)));
                    exp_q.push_back(t);
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
        cyc(); cyc();
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_saturation();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
